pid_sequencer: RTL and testbench
================================

# pid_sequencer

Control-loop sequencer for the line follower's PID datapath. Generates the fixed control-period tick, requests and captures one sensor position per period, holds it stable at the PID input, and waits out the PID pipeline. It then latches the PID result and mixes it with a base speed into saturated left/right motor duties. It also detects a lost line (repeated sensor timeouts) and forces the motors to stop.

## Interface
- SAMPLE_DIV, 100_000: clock cycles per control period.
- REQ_TIMEOUT, 1_000: cycles to wait for sens_valid after a request.
- PID_LATENCY, 6: cycles from pid_position update to a settled pid_output.
- LOST_LIMIT, 8: consecutive timeouts before lost asserts.
- BASE_SPEED, 600: duty offset, 0..1000.
- Constraint: REQ_TIMEOUT + PID_LATENCY + 3 < SAMPLE_DIV.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run loop; low forces idle and zero duty
- sens_req  out  1  one-cycle sample request
- sens_valid  in  1  sensor result strobe
- sens_position  in  11  line position 0..1000, centre 500
- pid_position  out  11  registered position driven to the PID
- pid_output  in  11  PID result 0..1000, centre 500
- left_duty  out  11  left motor duty 0..1000
- right_duty  out  11  right motor duty 0..1000
- duty_valid  out  1  one-cycle pulse when duties update
- lost  out  1  line-lost flag

## Operation
- Period timer: counts 0..SAMPLE_DIV-1 while enable is high and is held at 0 otherwise. tick = (count == SAMPLE_DIV-1).
- States:
  - IDLE: on tick, go to WAIT_SENS.
  - WAIT_SENS: sens_req is high on the first cycle only. Sub-counter counts cycles in state.
    - sens_valid high: load pid_position <= sens_position, go to WAIT_PID.
    - Counter reaches REQ_TIMEOUT-1 without sens_valid: timeout, go to IDLE.
  - WAIT_PID: count PID_LATENCY cycles, then go to LATCH.
  - LATCH: one cycle. Compute and register duties, pulse duty_valid, go to IDLE.
- Mixing in LATCH, 12-bit signed:
  - corr = pid_output - 500.
  - left = BASE_SPEED + corr; right = BASE_SPEED - corr.
  - Each result saturates to [0, 1000].
- Lost-line tracking:
  - Each timeout increments lost_cnt, which saturates at LOST_LIMIT. lost = (lost_cnt == LOST_LIMIT).
  - While lost = 1, LATCH is not reached and duties are 0. Both duties are forced to 0 in the same cycle lost rises.
  - Any accepted sens_valid clears lost_cnt and lost.
  - A timeout with lost still 0 leaves the previous duties unchanged.
- sens_valid outside WAIT_SENS is ignored.
- sens_position is not range-checked; it passes through as is.
- enable low: next state is IDLE from any state, duties 0, no duty_valid. pid_position and lost_cnt are held.

## Timing
- Reset values: sens_req 0, pid_position 500, left_duty 0, right_duty 0, duty_valid 0, lost 0. State IDLE, all counters 0.
- Tick at cycle t gives WAIT_SENS and sens_req = 1 at t+1.
- sens_valid accepted at cycle v gives pid_position updated at v+1.
- WAIT_PID occupies v+1 .. v+PID_LATENCY. LATCH is at v+PID_LATENCY+1.
- Duties and duty_valid are visible at v+PID_LATENCY+2.
- Timeout: exactly REQ_TIMEOUT cycles in WAIT_SENS. lost rises the cycle after the LOST_LIMIT-th timeout.
- Under the parameter constraint a tick never arrives outside IDLE, so there is no overrun path.
- Async reset mid-operation returns to the reset values immediately. The loop restarts on the first tick after release.

## Structure
- Package pid_ctrl_pkg holds:
  - state enum (IDLE, WAIT_SENS, WAIT_PID, LATCH)
  - POS_CENTER = 500, DUTY_MAX = 1000
  - position/duty width = 11
- Sub-module motor_mix: combinational. Takes pid_output and BASE_SPEED, produces saturated left/right. pid_sequencer registers its outputs in LATCH.

## Test plan
Params for all tests: SAMPLE_DIV=50, REQ_TIMEOUT=10, PID_LATENCY=6, LOST_LIMIT=3, BASE_SPEED=600.
- Centred line: sens_valid 2 cycles after sens_req with position 500, pid_output 500 -> pid_position 500; left=right=600; duty_valid pulses exactly 8 cycles after the accept cycle, once per 50-cycle period.
- Steer and saturation:
  - pid_output 800 -> left 900, right 300.
  - pid_output 0 -> left 100, right 1000 (clipped from 1100).
  - pid_output 1000 -> left 1000 (clipped from 1100), right 100.
- Lost line: no sens_valid for 3 periods -> each timeout after 10 cycles; lost=1 and duties 0 after the third. A valid sample of 500 in period 4 -> lost=0, duties 600/600.
- Enable drop: enable low during WAIT_PID -> IDLE next cycle, duties 0, no duty_valid. Re-enable -> first sens_req 50 cycles later.
- Stray strobe: sens_valid during IDLE and WAIT_PID with position 900 -> pid_position unchanged.
- Async reset mid-WAIT_SENS, not aligned to clk -> all outputs at reset values before the next edge. Normal period resumes after release.

Source files
------------

// File: rtl/pid_ctrl_pkg.sv
// Shared types and constants for the line-follower PID control loop.
// Holds the sequencer state encoding, position/duty widths and the duty clamp helper.
package pid_ctrl_pkg;

    localparam int POS_W      = 11;
    localparam int POS_CENTER = 500;
    localparam int DUTY_MAX   = 1000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SENS = 2'd1,
        WAIT_PID  = 2'd2,
        LATCH     = 2'd3
    } state_t;

    // Clamp a signed mixing result into the legal duty range [0, DUTY_MAX].
    function automatic logic [POS_W-1:0] sat_duty(input logic signed [12:0] v);
        logic [POS_W-1:0] res;
        if (v < 13'sd0)
            res = '0;
        else if (v > $signed(13'(DUTY_MAX)))
            res = POS_W'(DUTY_MAX);
        else
            res = v[POS_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/motor_mix.sv
// Differential mixer: base speed +/- (pid_output - centre), each side clamped to [0, DUTY_MAX].
// Purely combinational, zero latency, no flow control.
module motor_mix
    import pid_ctrl_pkg::*;
(
    input  logic [POS_W-1:0] i_pid_output,
    input  logic [POS_W-1:0] i_base_speed,
    output logic [POS_W-1:0] o_left_duty,
    output logic [POS_W-1:0] o_right_duty
);

    logic signed [12:0] w_corr;
    logic signed [12:0] w_base;
    logic signed [12:0] w_left;
    logic signed [12:0] w_right;

    // One bit of headroom beyond 12 bits keeps out-of-range 11-bit inputs from wrapping.
    assign w_corr  = $signed({2'b00, i_pid_output}) - $signed(13'(POS_CENTER));
    assign w_base  = $signed({2'b00, i_base_speed});
    assign w_left  = w_base + w_corr;
    assign w_right = w_base - w_corr;

    assign o_left_duty  = sat_duty(w_left);
    assign o_right_duty = sat_duty(w_right);

endmodule

// File: rtl/pid_sequencer.sv
// Control-period sequencer: request sample, hold it for the PID, wait out PID latency, latch mixed duties.
// Duties appear PID_LATENCY+2 cycles after sample accept; no backpressure, sensor timeouts feed lost-line detection.
module pid_sequencer
    import pid_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV  = 100_000,
    parameter int REQ_TIMEOUT = 1_000,
    parameter int PID_LATENCY = 6,
    parameter int LOST_LIMIT  = 8,
    parameter int BASE_SPEED  = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             sens_req,
    input  logic             sens_valid,
    input  logic [POS_W-1:0] sens_position,
    output logic [POS_W-1:0] pid_position,
    input  logic [POS_W-1:0] pid_output,
    output logic [POS_W-1:0] left_duty,
    output logic [POS_W-1:0] right_duty,
    output logic             duty_valid,
    output logic             lost
);

    localparam int PER_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SUB_MAX = (REQ_TIMEOUT > PID_LATENCY) ? REQ_TIMEOUT : PID_LATENCY;
    localparam int SUB_W   = $clog2(SUB_MAX + 1);
    localparam int LOST_W  = $clog2(LOST_LIMIT + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PER_W-1:0]    r_period_cnt;
    logic [SUB_W-1:0]    r_sub_cnt;
    logic [LOST_W-1:0]   r_lost_cnt;
    logic [POS_W-1:0]    r_pid_position;
    logic [POS_W-1:0]    r_left_duty;
    logic [POS_W-1:0]    r_right_duty;
    logic                r_duty_valid;

    logic                w_tick;
    logic                w_accept;
    logic                w_timeout;
    logic                w_pid_done;
    logic                w_lost;
    logic                w_sens_req;
    logic                w_in_latch;
    logic [POS_W-1:0]    w_mix_left;
    logic [POS_W-1:0]    w_mix_right;

    assign w_tick     = enable && (r_period_cnt == PER_W'(SAMPLE_DIV - 1));
    assign w_accept   = enable && (r_state == WAIT_SENS) && sens_valid;
    assign w_timeout  = enable && (r_state == WAIT_SENS) && !sens_valid
                        && (r_sub_cnt == SUB_W'(REQ_TIMEOUT - 1));
    assign w_pid_done = (r_state == WAIT_PID) && (r_sub_cnt == SUB_W'(PID_LATENCY - 1));
    assign w_lost     = (r_lost_cnt == LOST_W'(LOST_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_period_cnt <= '0;
        else if (!enable || w_tick)
            r_period_cnt <= '0;
        else
            r_period_cnt <= r_period_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:      if (w_tick) w_state_next = WAIT_SENS;
            WAIT_SENS: begin
                if (w_accept)
                    w_state_next = WAIT_PID;
                else if (w_timeout)
                    w_state_next = IDLE;
            end
            WAIT_PID:  if (w_pid_done) w_state_next = LATCH;
            LATCH:     w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
        if (!enable)
            w_state_next = IDLE;
    end

    always_comb begin
        w_sens_req = 1'b0;
        w_in_latch = 1'b0;
        unique case (r_state)
            WAIT_SENS: w_sens_req = (r_sub_cnt == '0);
            LATCH:     w_in_latch = enable;
            default:   ;
        endcase
    end

    // Cycles spent in the current state; restarts on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sub_cnt <= '0;
        else if (w_state_next != r_state)
            r_sub_cnt <= '0;
        else if (r_state == WAIT_SENS || r_state == WAIT_PID)
            r_sub_cnt <= r_sub_cnt + 1'b1;
    end

    motor_mix u_motor_mix (
        .i_pid_output (pid_output),
        .i_base_speed (POS_W'(BASE_SPEED)),
        .o_left_duty  (w_mix_left),
        .o_right_duty (w_mix_right)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pid_position <= POS_W'(POS_CENTER);
            r_left_duty    <= '0;
            r_right_duty   <= '0;
            r_duty_valid   <= 1'b0;
            r_lost_cnt     <= '0;
        end else begin
            r_duty_valid <= 1'b0;
            if (!enable) begin
                r_left_duty  <= '0;
                r_right_duty <= '0;
            end else begin
                if (w_accept) begin
                    r_pid_position <= sens_position;
                    r_lost_cnt     <= '0;
                end
                // Motors stop on the same edge that the final timeout makes lost rise.
                if (w_timeout) begin
                    if (!w_lost)
                        r_lost_cnt <= r_lost_cnt + 1'b1;
                    if (r_lost_cnt >= LOST_W'(LOST_LIMIT - 1)) begin
                        r_left_duty  <= '0;
                        r_right_duty <= '0;
                    end
                end
                if (w_in_latch) begin
                    r_left_duty  <= w_mix_left;
                    r_right_duty <= w_mix_right;
                    r_duty_valid <= 1'b1;
                end
            end
        end
    end

    assign sens_req     = w_sens_req;
    assign pid_position = r_pid_position;
    assign left_duty    = r_left_duty;
    assign right_duty   = r_right_duty;
    assign duty_valid   = r_duty_valid;
    assign lost         = w_lost;

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed bench for pid_sequencer with short periods; expected values are hand-derived.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pid_sequencer;

    localparam int SD = 50;
    localparam int RT = 10;
    localparam int PL = 6;
    localparam int LL = 3;
    localparam int BS = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sens_req;
    logic        sens_valid;
    logic [10:0] sens_position;
    logic [10:0] pid_position;
    logic [10:0] pid_output;
    logic [10:0] left_duty;
    logic [10:0] right_duty;
    logic        duty_valid;
    logic        lost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pid_sequencer #(
        .SAMPLE_DIV  (SD),
        .REQ_TIMEOUT (RT),
        .PID_LATENCY (PL),
        .LOST_LIMIT  (LL),
        .BASE_SPEED  (BS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sens_req      (sens_req),
        .sens_valid    (sens_valid),
        .sens_position (sens_position),
        .pid_position  (pid_position),
        .pid_output    (pid_output),
        .left_duty     (left_duty),
        .right_duty    (right_duty),
        .duty_valid    (duty_valid),
        .lost          (lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Falling edges until sens_req is seen; -1 if the budget runs out.
    task automatic wait_req(output int n);
        n = -1;
        for (int i = 1; i <= 2 * SD; i++) begin
            @(negedge clk);
            if (sens_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Present one sample in the current cycle; lat = cycles from accept to duty_valid.
    task automatic do_sample(input logic [10:0] pos, input logic [10:0] pid, output int lat);
        sens_valid    = 1'b1;
        sens_position = pos;
        pid_output    = pid;
        lat           = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            sens_valid = 1'b0;
            if (i == 1) begin
                chk("pos_load", 32'(pid_position), 32'(pos));
                chk("lost_clr_on_accept", 32'(lost), 32'd0);
            end
            if (duty_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    int          n;
    int          lat;
    int          dv_seen;
    logic [10:0] steer_pid [3] = '{11'd800, 11'd0,    11'd1000};
    logic [10:0] steer_l   [3] = '{11'd900, 11'd100,  11'd1000};
    logic [10:0] steer_r   [3] = '{11'd300, 11'd1000, 11'd100};

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        sens_valid    = 1'b0;
        sens_position = '0;
        pid_output    = 11'd500;
        repeat (2) @(negedge clk);
        chk("rst_sens_req", 32'(sens_req), 32'd0);
        chk("rst_pid_pos", 32'(pid_position), 32'd500);
        chk("rst_left", 32'(left_duty), 32'd0);
        chk("rst_right", 32'(right_duty), 32'd0);
        chk("rst_dv", 32'(duty_valid), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        wait_req(n);
        chk("first_req", 32'(n), 32'(SD));

        // Centred line, accept two cycles after the request.
        @(negedge clk);
        @(negedge clk);
        do_sample(11'd500, 11'd500, lat);
        chk("centre_lat", 32'(lat), 32'd8);
        chk("centre_left", 32'(left_duty), 32'd600);
        chk("centre_right", 32'(right_duty), 32'd600);
        @(negedge clk);
        chk("dv_one_shot", 32'(duty_valid), 32'd0);
        wait_req(n);
        chk("period_centre", 32'(n), 32'(SD - 11));

        // Steering and saturation, accept in the request cycle.
        for (int k = 0; k < 3; k++) begin
            do_sample(11'd500, steer_pid[k], lat);
            chk("steer_lat", 32'(lat), 32'd8);
            chk("steer_left", 32'(left_duty), 32'(steer_l[k]));
            chk("steer_right", 32'(right_duty), 32'(steer_r[k]));
            wait_req(n);
            chk("period_steer", 32'(n), 32'(SD - 8));
        end

        // Stray strobe during WAIT_PID must not disturb the held position.
        sens_valid    = 1'b1;
        sens_position = 11'd300;
        pid_output    = 11'd500;
        @(negedge clk);
        sens_valid = 1'b0;
        @(negedge clk);
        sens_valid    = 1'b1;
        sens_position = 11'd900;
        @(negedge clk);
        sens_valid = 1'b0;
        chk("stray_wait_pid", 32'(pid_position), 32'd300);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (duty_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("stray_dv_lat", 32'(n), 32'd5);
        chk("stray_left", 32'(left_duty), 32'd600);
        chk("stray_right", 32'(right_duty), 32'd600);
        // Now in IDLE: another stray strobe.
        sens_valid    = 1'b1;
        sens_position = 11'd900;
        @(negedge clk);
        sens_valid = 1'b0;
        chk("stray_idle", 32'(pid_position), 32'd300);
        wait_req(n);
        chk("period_stray", 32'(n), 32'(SD - 9));

        // Three periods with no sensor answer; a strobe right after each timeout is ignored.
        for (int p = 0; p < 3; p++) begin
            repeat (RT - 1) @(negedge clk);
            chk("lost_before_to", 32'(lost), 32'd0);
            @(negedge clk);
            chk("lost_after_to", 32'(lost), (p == 2) ? 32'd1 : 32'd0);
            chk("to_left", 32'(left_duty), (p == 2) ? 32'd0 : 32'd600);
            chk("to_right", 32'(right_duty), (p == 2) ? 32'd0 : 32'd600);
            sens_valid    = 1'b1;
            sens_position = 11'd900;
            @(negedge clk);
            sens_valid = 1'b0;
            chk("stray_after_to", 32'(pid_position), 32'd300);
            wait_req(n);
            chk("period_lost", 32'(n), 32'(SD - RT - 1));
        end
        chk("lost_held", 32'(lost), 32'd1);
        do_sample(11'd500, 11'd500, lat);
        chk("recover_lat", 32'(lat), 32'd8);
        chk("recover_left", 32'(left_duty), 32'd600);
        chk("recover_right", 32'(right_duty), 32'd600);
        wait_req(n);
        chk("period_recover", 32'(n), 32'(SD - 8));

        // Enable drop in WAIT_PID.
        sens_valid    = 1'b1;
        sens_position = 11'd500;
        pid_output    = 11'd800;
        @(negedge clk);
        sens_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_left", 32'(left_duty), 32'd0);
        chk("dis_right", 32'(right_duty), 32'd0);
        dv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (duty_valid === 1'b1) dv_seen++;
            @(negedge clk);
        end
        chk("dis_no_dv", 32'(dv_seen), 32'd0);
        chk("dis_left_hold", 32'(left_duty), 32'd0);
        chk("dis_pid_pos_held", 32'(pid_position), 32'd500);
        enable = 1'b1;
        wait_req(n);
        chk("reenable_req", 32'(n), 32'(SD));
        do_sample(11'd700, 11'd800, lat);
        chk("reenable_lat", 32'(lat), 32'd8);
        chk("reenable_left", 32'(left_duty), 32'd900);
        chk("reenable_right", 32'(right_duty), 32'd300);
        wait_req(n);
        chk("period_reenable", 32'(n), 32'(SD - 8));

        // Asynchronous reset while sens_req is high, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sens_req", 32'(sens_req), 32'd0);
        chk("arst_pid_pos", 32'(pid_position), 32'd500);
        chk("arst_left", 32'(left_duty), 32'd0);
        chk("arst_right", 32'(right_duty), 32'd0);
        chk("arst_dv", 32'(duty_valid), 32'd0);
        chk("arst_lost", 32'(lost), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_req(n);
        chk("arst_first_req", 32'(n), 32'(SD));
        do_sample(11'd500, 11'd500, lat);
        chk("arst_lat", 32'(lat), 32'd8);
        chk("arst_resume_left", 32'(left_duty), 32'd600);
        chk("arst_resume_right", 32'(right_duty), 32'd600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
